seq_detector_param: RTL and testbench
=====================================

// Module: seq_detector_param
// PURPOSE
//  Serial-bit pattern detector with a programmable pattern (1..MAX_LEN bits) and selectable
//  overlap / non-overlap matching. Adds an input-valid qualifier and a saturating match counter.
//  Sits between a bit-serial source and control logic. Comes out of reset preloaded with
//  DEF_PATTERN/DEF_LEN, so the default build is a drop-in 3-bit "010" detector.
// PARAMETERS
//  MAX_LEN      8        longest supported pattern, in bits (>=2)
//  DEF_PATTERN  8'b010   pattern loaded at reset; bit [DEF_LEN-1] is the first bit received
//  DEF_LEN      3        pattern length loaded at reset (1..MAX_LEN)
//  DEF_OVERLAP  1        overlap mode loaded at reset
//  CNT_W        16       width of match_cnt
// PORTS
//  clk          in   1          rising-edge clock
//  reset        in   1          asynchronous, active-low reset
//  cfg_load     in   1          1-cycle strobe; samples cfg_pattern, cfg_len and cfg_overlap
//  cfg_pattern  in   MAX_LEN    pattern, MSB-first within the low cfg_len bits
//  cfg_len      in   LW         pattern length; LW = $clog2(MAX_LEN+1)
//  cfg_overlap  in   1          1 = overlapping matches, 0 = non-overlapping
//  x_valid      in   1          x is sampled only when this is 1
//  x            in   1          serial data bit
//  y            out  1          1-cycle match pulse
//  armed        out  1          valid configuration held; detection enabled
//  cfg_err      out  1          1-cycle pulse: cfg_load rejected
//  match_cnt    out  CNT_W      saturating count of matches since reset/cfg_load
// BEHAVIOUR
//  Reset (reset=0, async): hist=0, fill=0, y=0, cfg_err=0, match_cnt=0, armed=1.
//    Pattern, len and overlap take their DEF_* values.
//  FSM states: UNCFG (armed=0), RUN (armed=1). Reset -> RUN.
//    Valid cfg_load (1 <= cfg_len <= MAX_LEN) -> RUN.
//    Invalid cfg_load (cfg_len=0 or cfg_len>MAX_LEN) -> UNCFG and cfg_err=1 for one cycle.
//  Any cfg_load clears hist, fill and match_cnt. cfg_load and x_valid in the same cycle:
//    the load wins and the bit is discarded.
//  Accepted bit (RUN && x_valid && !cfg_load):
//    hist <= {hist[MAX_LEN-2:0], x}; fill <= min(fill+1, MAX_LEN).
//  Match condition on the shifted-in view: fill_next >= len AND hist_next[len-1:0] == pattern[len-1:0].
//  On a match:
//    y=1 in the cycle after the accepting edge; y is registered and asserts for exactly one cycle.
//    match_cnt increments on the same edge and saturates at all-ones.
//    Non-overlap mode: fill <= 0, so the next match needs len fresh bits.
//    Overlap mode: hist and fill are retained.
//  x_valid=0: hist, fill and count hold; y=0.
//  In UNCFG, x and x_valid are ignored; y stays 0.
//  len=1 is legal: every bit equal to pattern[0] matches.
//  Reset mid-stream aborts any partial match; no y pulse is produced for it.
//  Fully synchronous apart from reset; no combinational input->output path.
// STRUCTURE
//  Include file seq_det_defs.vh holds:
//    MAX_LEN_DEF, LW function/macro, FSM state encodings (ST_UNCFG=1'b0, ST_RUN=1'b1).
//  One sub-module, seq_window:
//    MAX_LEN shift register plus saturating fill counter, with clear and shift-enable inputs.
//  The top level holds the config registers, FSM, masked comparator, y register and match counter.
// TESTING
//  T1 default 010, overlap: after reset, x_valid=1 and x=0,1,0,1,0,0,1,0,1,0,0,1,0
//     -> y pulses after bits 3,5,8,10,13; match_cnt=5.
//  T2 same stream after cfg_load(pattern=010, len=3, overlap=0)
//     -> y after bits 3,8,13; match_cnt=3.
//  T3 cfg_load(pattern=8'b1011_0111, len=8, overlap=1), stream 1011_0111_0111
//     -> y after bit 8 only; x_valid=0 gaps inserted mid-pattern leave the result unchanged.
//  T4 cfg_load with len=0, then len=9 -> cfg_err pulses each time and armed=0; y stays 0 on any stream.
//     Next valid load -> armed=1.
//  T5 reset asserted after bits 0,1 of 010, then released; feed 0
//     -> no y pulse; 0,1,0 afterwards -> y after that 3rd bit.
//  T6 CNT_W=2, len=1, pattern=1, feed five 1s -> match_cnt saturates at 3; y pulses 5 times.
//     cfg_load in the same cycle as x_valid -> that bit is not counted.

Source files
------------

// File: rtl/seq_detector_param_pkg.sv
// Shared types and helpers for the programmable serial pattern detector.
package seq_detector_param_pkg;

  localparam int unsigned MAX_LEN_DEF = 8;

  typedef enum logic {
    ST_UNCFG = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  // Width needed to hold a length in the range 0..max_len inclusive.
  function automatic int unsigned len_w(input int unsigned max_len);
    return $clog2(max_len + 1);
  endfunction

endpackage

// File: rtl/seq_window.sv
// Bit history shift register with a saturating fill counter.
module seq_window
  import seq_detector_param_pkg::*;
#(
  parameter int unsigned MAX_LEN = MAX_LEN_DEF,
  parameter int unsigned LW      = len_w(MAX_LEN)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clr,
  input  logic               shift,
  input  logic               drop,
  input  logic               din,
  output logic [MAX_LEN-1:0] hist_nxt_c,
  output logic [LW-1:0]      fill_nxt_c
);

  logic [MAX_LEN-1:0] hist;
  logic [LW-1:0]      fill;

  // Shifted-in view, used by the comparator before the edge commits it.
  always_comb begin
    hist_nxt_c = {hist[MAX_LEN-2:0], din};
    fill_nxt_c = (fill == LW'(MAX_LEN)) ? fill : fill + LW'(1);
  end

  // drop restarts the fill count after a non-overlapping match.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hist <= '0;
      fill <= '0;
    end else if (clr) begin
      hist <= '0;
      fill <= '0;
    end else if (shift) begin
      hist <= hist_nxt_c;
      fill <= drop ? '0 : fill_nxt_c;
    end
  end

endmodule

// File: rtl/seq_detector_param.sv
// Programmable serial pattern detector with overlap control and saturating match count.
module seq_detector_param
  import seq_detector_param_pkg::*;
#(
  parameter int unsigned        MAX_LEN     = MAX_LEN_DEF,
  parameter logic [MAX_LEN-1:0] DEF_PATTERN = MAX_LEN'(3'b010),
  parameter int unsigned        DEF_LEN     = 3,
  parameter bit                 DEF_OVERLAP = 1'b1,
  parameter int unsigned        CNT_W       = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       cfg_load,
  input  logic [MAX_LEN-1:0]         cfg_pattern,
  input  logic [len_w(MAX_LEN)-1:0]  cfg_len,
  input  logic                       cfg_overlap,
  input  logic                       x_valid,
  input  logic                       x,
  output logic                       y,
  output logic                       armed,
  output logic                       cfg_err,
  output logic [CNT_W-1:0]           match_cnt
);

  localparam int unsigned LW = len_w(MAX_LEN);

  state_e             state;
  logic [MAX_LEN-1:0] pattern_q;
  logic [LW-1:0]      len_q;
  logic               overlap_q;

  logic [MAX_LEN-1:0] hist_nxt_c;
  logic [LW-1:0]      fill_nxt_c;
  logic [MAX_LEN-1:0] mask_c;
  logic               cfg_ok_c;
  logic               accept_c;
  logic               match_c;
  logic               drop_c;

  seq_window #(
    .MAX_LEN (MAX_LEN),
    .LW      (LW)
  ) u_window (
    .clk        (clk),
    .reset      (reset),
    .clr        (cfg_load),
    .shift      (accept_c),
    .drop       (drop_c),
    .din        (x),
    .hist_nxt_c (hist_nxt_c),
    .fill_nxt_c (fill_nxt_c)
  );

  // Masked comparison of the low len_q bits of the shifted-in history.
  always_comb begin
    mask_c = '0;
    for (int i = 0; i < int'(MAX_LEN); i++) begin
      mask_c[i] = (i < int'(len_q));
    end
    cfg_ok_c = (cfg_len != '0) && (cfg_len <= LW'(MAX_LEN));
    accept_c = (state == ST_RUN) && x_valid && !cfg_load;
    match_c  = accept_c && (fill_nxt_c >= len_q) &&
               (((hist_nxt_c ^ pattern_q) & mask_c) == '0);
    drop_c   = match_c && !overlap_q;
  end

  assign armed = (state == ST_RUN);

  // Config registers, FSM, match pulse and counter; a load always wins over data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_RUN;
      pattern_q <= DEF_PATTERN;
      len_q     <= LW'(DEF_LEN);
      overlap_q <= DEF_OVERLAP;
      y         <= 1'b0;
      cfg_err   <= 1'b0;
      match_cnt <= '0;
    end else begin
      y       <= match_c;
      cfg_err <= cfg_load && !cfg_ok_c;
      if (cfg_load) begin
        match_cnt <= '0;
        if (cfg_ok_c) begin
          state     <= ST_RUN;
          pattern_q <= cfg_pattern;
          len_q     <= cfg_len;
          overlap_q <= cfg_overlap;
        end else begin
          state <= ST_UNCFG;
        end
      end else if (match_c && (match_cnt != '1)) begin
        match_cnt <= match_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench for seq_detector_param; a second instance with a 2-bit counter covers saturation.
module tb_seq_detector_param;

  logic       clk = 1'b0;
  logic       reset;
  logic       cfg_load;
  logic [7:0] cfg_pattern;
  logic [3:0] cfg_len;
  logic       cfg_overlap;
  logic       x_valid;
  logic       x;

  logic        y, armed, cfg_err;
  logic [15:0] match_cnt;
  logic        y2, armed2, cfg_err2;
  logic [1:0]  cnt2;

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  seq_detector_param u_dut (
    .clk         (clk),
    .reset       (reset),
    .cfg_load    (cfg_load),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .x_valid     (x_valid),
    .x           (x),
    .y           (y),
    .armed       (armed),
    .cfg_err     (cfg_err),
    .match_cnt   (match_cnt)
  );

  seq_detector_param #(.CNT_W(2)) u_dut_sat (
    .clk         (clk),
    .reset       (reset),
    .cfg_load    (cfg_load),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .x_valid     (x_valid),
    .x           (x),
    .y           (y2),
    .armed       (armed2),
    .cfg_err     (cfg_err2),
    .match_cnt   (cnt2)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic feed(input logic b, input logic exp_y, input string tag);
    @(negedge clk);
    x_valid = 1'b1;
    x       = b;
    @(posedge clk);
    #1;
    x_valid = 1'b0;
    check_eq(tag, 32'(y), 32'(exp_y));
  endtask

  task automatic idle(input string tag);
    @(negedge clk);
    x_valid = 1'b0;
    @(posedge clk);
    #1;
    check_eq(tag, 32'(y), 32'd0);
  endtask

  // Bits go out MSB-first from bits[n-1]; exp_y holds the expected y after each bit.
  task automatic run_stream(input string tag, input logic [15:0] bits, input int n,
                            input logic [15:0] exp_y, input bit gap);
    for (int i = n - 1; i >= 0; i--) begin
      feed(bits[i], exp_y[i], tag);
      if (gap && (i % 2 == 1)) idle({tag, "_gap"});
    end
  endtask

  task automatic do_cfg(input logic [7:0] pat, input logic [3:0] len, input logic ovl,
                        input logic exp_err, input logic exp_armed, input string tag);
    @(negedge clk);
    cfg_load    = 1'b1;
    cfg_pattern = pat;
    cfg_len     = len;
    cfg_overlap = ovl;
    @(posedge clk);
    #1;
    cfg_load = 1'b0;
    check_eq({tag, "_err"},   32'(cfg_err), 32'(exp_err));
    check_eq({tag, "_armed"}, 32'(armed),   32'(exp_armed));
  endtask

  initial begin
    reset       = 1'b0;
    cfg_load    = 1'b0;
    cfg_pattern = '0;
    cfg_len     = '0;
    cfg_overlap = 1'b0;
    x_valid     = 1'b0;
    x           = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    check_eq("rst_y",     32'(y),       32'd0);
    check_eq("rst_armed", 32'(armed),   32'd1);
    check_eq("rst_err",   32'(cfg_err), 32'd0);
    check_eq("rst_cnt",   32'(match_cnt), 32'd0);

    // T1: default 010, overlapping
    run_stream("t1", 16'b0101001010010, 13, 16'b0010100101001, 1'b0);
    check_eq("t1_cnt", 32'(match_cnt), 32'd5);

    // T2: same stream, non-overlapping
    do_cfg(8'b010, 4'd3, 1'b0, 1'b0, 1'b1, "t2_cfg");
    check_eq("t2_cnt_clr", 32'(match_cnt), 32'd0);
    run_stream("t2", 16'b0101001010010, 13, 16'b0010000100001, 1'b0);
    check_eq("t2_cnt", 32'(match_cnt), 32'd3);

    // T3: full-width pattern with valid gaps
    do_cfg(8'b1011_0111, 4'd8, 1'b1, 1'b0, 1'b1, "t3_cfg");
    run_stream("t3", 16'b1011_0111_0111, 12, 16'b0000_0001_0000, 1'b1);
    check_eq("t3_cnt", 32'(match_cnt), 32'd1);

    // T4: rejected lengths
    do_cfg(8'b010, 4'd0, 1'b1, 1'b1, 1'b0, "t4_len0");
    idle("t4_idle");
    check_eq("t4_err_pulse", 32'(cfg_err), 32'd0);
    run_stream("t4_uncfg", 16'b0101001010010, 13, 16'b0, 1'b0);
    check_eq("t4_cnt", 32'(match_cnt), 32'd0);
    do_cfg(8'b010, 4'd9, 1'b1, 1'b1, 1'b0, "t4_len9");
    do_cfg(8'b010, 4'd3, 1'b1, 1'b0, 1'b1, "t4_valid");

    // T5: reset in the middle of a partial match
    feed(1'b0, 1'b0, "t5_pre0");
    feed(1'b1, 1'b0, "t5_pre1");
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_eq("t5_rst_y",     32'(y),     32'd0);
    check_eq("t5_rst_armed", 32'(armed), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    feed(1'b0, 1'b0, "t5_after");
    run_stream("t5_next", 16'b010, 3, 16'b001, 1'b0);
    check_eq("t5_cnt", 32'(match_cnt), 32'd1);

    // T6: len=1 with a 2-bit saturating counter
    do_cfg(8'b1, 4'd1, 1'b1, 1'b0, 1'b1, "t6_cfg");
    check_eq("t6_cnt_clr", 32'(cnt2), 32'd0);
    for (int i = 0; i < 5; i++) begin
      feed(1'b1, 1'b1, "t6_y");
      check_eq("t6_y2", 32'(y2), 32'd1);
    end
    check_eq("t6_sat", 32'(cnt2), 32'd3);
    check_eq("t6_wide", 32'(match_cnt), 32'd5);
    feed(1'b0, 1'b0, "t6_zero");
    @(negedge clk);
    cfg_load = 1'b1;
    x_valid  = 1'b1;
    x        = 1'b1;
    @(posedge clk);
    #1;
    cfg_load = 1'b0;
    x_valid  = 1'b0;
    check_eq("t6_coll_y", 32'(y2), 32'd0);
    check_eq("t6_coll_cnt", 32'(cnt2), 32'd0);
    idle("t6_idle");
    check_eq("t6_no_count", 32'(cnt2), 32'd0);
    feed(1'b1, 1'b1, "t6_post");
    check_eq("t6_post_cnt", 32'(cnt2), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
